// File: rtl/ex_mem_stage.sv
// Execute-to-memory boundary: resolves branches/jumps, issues a registered PC redirect pulse,
// and holds the memory-stage bundle in a two-entry (head + skid) FIFO.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_alu_result,
  input  logic        in_zero_flag,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_branch,
  input  logic        in_is_beq,
  input  logic        in_is_jal,
  input  logic        in_is_jalr,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic        out_misaligned,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        misaligned;
  } entry_t;

  entry_t      head_q, skid_q, new_entry;
  logic        head_valid_q, skid_valid_q;
  logic        accept, taken, misaligned, is_jump;
  logic [31:0] target;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    is_jump    = in_is_jal | in_is_jalr;
    taken      = is_jump | (in_is_branch & (in_is_beq ? in_zero_flag : in_alu_result[0]));
    target     = in_is_jalr ? {in_alu_result[31:1], 1'b0} : in_pc + in_imm;
    misaligned = taken & (target[1:0] != 2'b00);

    new_entry            = '0;
    new_entry.result     = is_jump ? in_pc + 32'd4 : in_alu_result;
    new_entry.store_data = in_rs2_data;
    new_entry.rd         = in_rd;
    new_entry.funct3     = in_funct3;
    // A misaligned target turns the instruction into a side-effect-free exception carrier.
    new_entry.mem_read   = in_mem_read & ~misaligned;
    new_entry.mem_write  = in_mem_write & ~misaligned;
    new_entry.reg_write  = in_reg_write & ~misaligned;
    new_entry.misaligned = misaligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!head_valid_q || out_ready) begin
      // Head is free this edge; skid has priority to keep FIFO order.
      if (skid_valid_q) begin
        head_q       <= skid_q;
        head_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        head_q       <= new_entry;
        head_valid_q <= 1'b1;
      end else begin
        head_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= new_entry;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & taken & ~misaligned;
      if (accept & taken & ~misaligned) begin
        redirect_pc <= target;
      end
    end
  end

  assign out_valid      = head_valid_q;
  assign out_result     = head_q.result;
  assign out_store_data = head_q.store_data;
  assign out_rd         = head_q.rd;
  assign out_funct3     = head_q.funct3;
  assign out_mem_read   = head_q.mem_read;
  assign out_mem_write  = head_q.mem_write;
  assign out_reg_write  = head_q.reg_write;
  assign out_misaligned = head_q.misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written buffer/flush/reset sequences,
// and a randomized run checked against a queue-based reference model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_alu_result, in_rs2_data;
  logic        in_zero_flag;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_is_branch, in_is_beq, in_is_jal, in_is_jalr;
  logic        in_mem_read, in_mem_write, in_reg_write;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_mem_read, out_mem_write, out_reg_write, out_misaligned;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_imm(in_imm), .in_alu_result(in_alu_result), .in_zero_flag(in_zero_flag),
    .in_rs2_data(in_rs2_data), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_is_branch(in_is_branch), .in_is_beq(in_is_beq), .in_is_jal(in_is_jal),
    .in_is_jalr(in_is_jalr), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one expected memory-stage entry per accepted instruction.
  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, rw, mis;
    logic        redir;
    logic [31:0] rpc;
  } ent_t;

  ent_t        q[$];
  logic        exp_rv;
  logic [31:0] exp_rpc;

  function automatic ent_t ref_entry();
    ent_t        e;
    bit          tk;
    logic [31:0] tgt;
    if (in_is_jal || in_is_jalr) tk = 1;
    else if (in_is_branch) tk = in_is_beq ? in_zero_flag : (in_alu_result % 2 == 1);
    else tk = 0;
    if (in_is_jalr) tgt = in_alu_result - (in_alu_result % 2);
    else tgt = in_pc + in_imm;
    e.mis    = tk && (tgt % 4 != 0);
    e.result = (in_is_jal || in_is_jalr) ? in_pc + 4 : in_alu_result;
    e.store  = in_rs2_data;
    e.rd     = in_rd;
    e.f3     = in_funct3;
    e.mr     = in_mem_read && !e.mis;
    e.mw     = in_mem_write && !e.mis;
    e.rw     = in_reg_write && !e.mis;
    e.redir  = tk && !e.mis;
    e.rpc    = tgt;
    return e;
  endfunction

  task automatic model_step();
    ent_t e;
    bit   acc, pop;
    e   = ref_entry();
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    exp_rv = acc && e.redir;
    if (exp_rv) exp_rpc = e.rpc;
  endtask

  task automatic check_model(input string n);
    chk({n, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({n, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    chk({n, "_redirect_valid"}, 32'(redirect_valid), 32'(exp_rv));
    if (exp_rv) chk({n, "_redirect_pc"}, redirect_pc, exp_rpc);
    if (q.size() > 0) begin
      chk({n, "_result"}, out_result, q[0].result);
      chk({n, "_store"}, out_store_data, q[0].store);
      chk({n, "_ctl"}, {out_rd, out_funct3, out_mem_read, out_mem_write, out_reg_write,
                        out_misaligned},
          {q[0].rd, q[0].f3, q[0].mr, q[0].mw, q[0].rw, q[0].mis});
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc = 0; in_imm = 0; in_alu_result = 0; in_zero_flag = 0;
    in_rs2_data = 0; in_rd = 0; in_funct3 = 0; in_is_branch = 0; in_is_beq = 0;
    in_is_jal = 0; in_is_jalr = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    exp_rv = 0;
  endtask

  task automatic set_add(input logic [31:0] res);
    clear_inputs();
    in_valid = 1; in_alu_result = res; in_reg_write = 1; in_rd = 5'd3;
  endtask

  typedef struct {
    string       name;
    logic [31:0] pc, imm, alu;
    logic        zero;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  cls;  // {branch, beq, jal, jalr}
    logic        mr, mw, rw;
    logic [31:0] e_result;
    logic        e_mis, e_mr, e_mw, e_rw, e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] got[$];

  initial begin
    vecs[0]  = '{"beq_taken", 32'h100, 32'h20, 32'h0, 1'b1, 32'h0, 5'd0, 3'd0, 4'b1100,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h120};
    vecs[1]  = '{"beq_not_taken", 32'h100, 32'h20, 32'h5, 1'b0, 32'h0, 5'd0, 3'd0, 4'b1100,
                 1'b0, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{"bne_taken_back", 32'h400, 32'hFFFFFFF0, 32'h1, 1'b0, 32'h0, 5'd0, 3'd1,
                 4'b1000, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3F0};
    vecs[3]  = '{"blt_not_taken", 32'h400, 32'h40, 32'h0, 1'b1, 32'h0, 5'd0, 3'd4, 4'b1000,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"branch_misaligned", 32'h100, 32'h6, 32'h1, 1'b0, 32'h0, 5'd2, 3'd5,
                 4'b1000, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"jalr_aligned", 32'h200, 32'h0, 32'h1001, 1'b0, 32'h0, 5'd1, 3'd0, 4'b0001,
                 1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000};
    vecs[6]  = '{"jalr_1003_misaligned", 32'h200, 32'h0, 32'h1003, 1'b0, 32'h0, 5'd1, 3'd0,
                 4'b0001, 1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{"jalr_1006_misaligned", 32'h200, 32'h0, 32'h1006, 1'b0, 32'h0, 5'd1, 3'd0,
                 4'b0001, 1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"jal_wrap", 32'hFFFFFFFC, 32'h8, 32'h0, 1'b0, 32'h0, 5'd1, 3'd0, 4'b0010,
                 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4};
    vecs[9]  = '{"add", 32'h300, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 5'd7, 3'd0, 4'b0000,
                 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{"store", 32'h304, 32'h0, 32'h2000, 1'b0, 32'h12345678, 5'd0, 3'd2, 4'b0000,
                 1'b0, 1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{"load", 32'h308, 32'h0, 32'h2004, 1'b0, 32'h0, 5'd9, 3'd4, 4'b0000,
                 1'b1, 1'b0, 1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};

    out_ready = 0;
    clear_inputs();
    reset = 1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_redirect", {31'h0, redirect_valid}, 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_out_result", out_result, 32'h0);
    do_reset();

    // Directed single-instruction table.
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      in_valid = 1; out_ready = 1;
      in_pc = vecs[i].pc; in_imm = vecs[i].imm; in_alu_result = vecs[i].alu;
      in_zero_flag = vecs[i].zero; in_rs2_data = vecs[i].rs2; in_rd = vecs[i].rd;
      in_funct3 = vecs[i].f3;
      {in_is_branch, in_is_beq, in_is_jal, in_is_jalr} = vecs[i].cls;
      in_mem_read = vecs[i].mr; in_mem_write = vecs[i].mw; in_reg_write = vecs[i].rw;
      @(posedge clk);
      #1;
      clear_inputs();
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'h1);
      chk({vecs[i].name, "_result"}, out_result, vecs[i].e_result);
      chk({vecs[i].name, "_flags"}, {out_misaligned, out_mem_read, out_mem_write, out_reg_write},
          {vecs[i].e_mis, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_rw});
      chk({vecs[i].name, "_rd_f3_store"}, {out_rd, out_funct3, out_store_data[23:0]},
          {vecs[i].rd, vecs[i].f3, vecs[i].rs2[23:0]});
      chk({vecs[i].name, "_redirect"}, 32'(redirect_valid), 32'(vecs[i].e_redir));
      if (vecs[i].e_redir) chk({vecs[i].name, "_redirect_pc"}, redirect_pc, vecs[i].e_rpc);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_pulse_end"}, 32'(redirect_valid), 32'h0);
      chk({vecs[i].name, "_drained"}, 32'(out_valid), 32'h0);
    end

    // Stalled stream A,B,C must come out 1,2,3 in order.
    do_reset();
    out_ready = 0;
    set_add(32'd1);
    @(posedge clk); #1;
    chk("abc_ready_after_a", 32'(in_ready), 32'h1);
    set_add(32'd2);
    @(posedge clk); #1;
    chk("abc_ready_low_after_b", 32'(in_ready), 32'h0);
    set_add(32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abc_c_waits", 32'(in_ready), 32'h0);
    chk("abc_head_stable", out_result, 32'd1);
    out_ready = 1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      bit c_acc;
      if (out_valid) got.push_back(out_result);
      c_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (c_acc) in_valid = 0;
    end
    chk("abc_count", got.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) chk($sformatf("abc_order_%0d", k), got[k], 32'(k + 1));
    end

    // Full buffer, then flush with a taken JAL on the input.
    do_reset();
    out_ready = 0;
    set_add(32'hA);
    @(posedge clk); #1;
    set_add(32'hB);
    @(posedge clk); #1;
    clear_inputs();
    in_valid = 1; in_is_jal = 1; in_pc = 32'h800; in_imm = 32'h40; in_alu_result = 32'h77;
    in_reg_write = 1; flush = 1;
    @(posedge clk); #1;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_no_redirect", 32'(redirect_valid), 32'h0);
    clear_inputs();
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_stays_empty_%0d", k), 32'(out_valid), 32'h0);
    end

    // Reset with both entries full and a redirect pulse in flight.
    do_reset();
    out_ready = 0;
    set_add(32'h55);
    @(posedge clk); #1;
    clear_inputs();
    in_valid = 1; in_is_jal = 1; in_pc = 32'h1000; in_imm = 32'h100; in_reg_write = 1;
    @(posedge clk); #1;
    clear_inputs();
    chk("rst_pre_redirect", 32'(redirect_valid), 32'h1);
    chk("rst_pre_full", 32'(in_ready), 32'h0);
    reset = 1;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'h0);
    chk("rst_async_redirect", 32'(redirect_valid), 32'h0);
    chk("rst_async_redirect_pc", redirect_pc, 32'h0);
    chk("rst_async_out_result", out_result, 32'h0);
    chk("rst_async_in_ready", 32'(in_ready), 32'h1);
    #1;
    reset = 0;
    @(posedge clk); #1;
    chk("rst_after_in_ready", 32'(in_ready), 32'h1);
    chk("rst_after_out_valid", 32'(out_valid), 32'h0);

    // Randomized traffic against the queue model.
    do_reset();
    out_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      int sel;
      clear_inputs();
      sel           = $urandom_range(0, 4);
      in_valid      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      in_pc         = $urandom() & 32'hFFFFFFFC;
      in_imm        = ($urandom() & 32'hFFFFFFFC) |
                      (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
      in_alu_result = $urandom();
      in_zero_flag  = 1'($urandom_range(0, 1));
      in_rs2_data   = $urandom();
      in_rd         = 5'($urandom_range(0, 31));
      in_funct3     = 3'($urandom_range(0, 7));
      in_reg_write  = 1'($urandom_range(0, 1));
      case (sel)
        1: begin in_is_branch = 1; in_is_beq = 1'($urandom_range(0, 1)); in_reg_write = 0; end
        2: in_is_jal = 1;
        3: in_is_jalr = 1;
        4: begin in_mem_read = 1'($urandom_range(0, 1)); in_mem_write = ~in_mem_read; end
        default: ;
      endcase
      model_step();
      check_model($sformatf("rand_%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
